// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-ported register file.
// Build option: REGFILE_MP_BYPASS_EN enables same-cycle write-to-read forwarding.
package regfile_pkg;
    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int NREAD_DEF  = 2;
    localparam int NWRITE_DEF = 2;

    function automatic int addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared by writeback, bulk-cleared by flush.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NWRITE = NWRITE_DEF,
    parameter int AW     = addr_w(NREGS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic [NWRITE-1:0]    wr_en_i,
    input  logic [NWRITE*AW-1:0] wr_addr_i,
    input  logic                 iss_en_i,
    input  logic [AW-1:0]        iss_addr_i,
    output logic [NREGS-1:0]     busy_o
);
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Order matters: clear, then flush, then issue so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (!stall_i) begin
            for (int k = 0; k < NWRITE; k++) begin
                if (wr_en_i[k] && wr_addr_i[k*AW +: AW] != '0)
                    busy_d[wr_addr_i[k*AW +: AW]] = 1'b0;
            end
        end
        if (flush_i)
            busy_d = '0;
        if (!stall_i && iss_en_i && iss_addr_i != '0)
            busy_d[iss_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy_o = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with x0 hardwired to zero and a busy scoreboard.
// Build option: REGFILE_MP_BYPASS_EN forwards same-cycle write data to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = NREAD_DEF,
    parameter int NWRITE = NWRITE_DEF,
    parameter int AW     = addr_w(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic [NWRITE-1:0]      wr_en,
    input  logic [NWRITE*AW-1:0]   wr_addr,
    input  logic [NWRITE*XLEN-1:0] wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   flush
);
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy;

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NWRITE (NWRITE),
        .AW     (AW)
    ) u_sb (
        .clk_i      (clk),
        .rst_i      (rst),
        .stall_i    (stall),
        .flush_i    (flush),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .busy_o     (busy)
    );

    // Ascending port order lets the higher-index port win a same-address clash.
    always_comb begin
        regs_d = regs_q;
        if (!stall) begin
            for (int k = 0; k < NWRITE; k++) begin
                if (wr_en[k] && wr_addr[k*AW +: AW] != '0)
                    regs_d[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        ra      = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra = rd_addr[i*AW +: AW];
            rd_data[i*XLEN +: XLEN] = regs_q[ra];
            rd_busy[i] = busy[ra];
`ifdef REGFILE_MP_BYPASS_EN
            if (!stall && ra != '0) begin
                for (int k = 0; k < NWRITE; k++) begin
                    if (wr_en[k] && wr_addr[k*AW +: AW] == ra) begin
                        rd_data[i*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
                        rd_busy[i] = iss_en && (iss_addr == ra);
                    end
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
// Bypass expectations follow REGFILE_MP_BYPASS_EN when it is defined.
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;

    int checks = 0;
    int errors = 0;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush)
    );

    always #5 clk = ~clk;

    task automatic idle();
        wr_en  = 2'b00;
        iss_en = 1'b0;
        flush  = 1'b0;
        stall  = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            checks++;
            if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
                errors++;
                $display("FAIL reset a=%0d data=%h busy=%b want 0/00",
                         a, rd_data, rd_busy);
            end
        end
    endtask

    task automatic test_write_read();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'h0, 32'hDEADBEEF};
        tick();
        idle();
        rd_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_read data=%h busy=%b want deadbeef/0",
                     rd_data[31:0], rd_busy[0]);
        end
    endtask

    task automatic test_conflict();
        wr_en   = 2'b11;
        wr_addr = {5'd7, 5'd7};
        wr_data = {32'h2222, 32'h1111};
        tick();
        idle();
        rd_addr = {5'd0, 5'd7};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h2222) begin
            errors++;
            $display("FAIL conflict x7=%h want 2222", rd_data[31:0]);
        end
        wr_en   = 2'b11;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'hFFFF, 32'hFFFF};
        tick();
        idle();
        rd_addr = {5'd0, 5'd0};
        #1;
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL x0_write data=%h busy=%b want 0/00", rd_data, rd_busy);
        end
        wr_en   = 2'b11;
        wr_addr = {5'd11, 5'd10};
        wr_data = {32'hBBBB, 32'hAAAA};
        tick();
        idle();
        rd_addr = {5'd10, 5'd11};
        #1;
        checks++;
        if (rd_data !== {32'hAAAA, 32'hBBBB}) begin
            errors++;
            $display("FAIL two_ports data=%h want 0000aaaa0000bbbb", rd_data);
        end
    endtask

    task automatic test_scoreboard();
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        tick();
        idle();
        rd_addr = {5'd0, 5'd9};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_issue busy=%b want 1", rd_busy[0]);
        end
        stall   = 1'b1;
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd9};
        wr_data = {32'h0, 32'h99};
        tick();
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL sb_stall data=%h busy=%b want 0/1",
                     rd_data[31:0], rd_busy[0]);
        end
        stall = 1'b0;
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h99) begin
            errors++;
            $display("FAIL sb_write data=%h busy=%b want 99/0",
                     rd_data[31:0], rd_busy[0]);
        end
    endtask

    task automatic test_issue_priority();
        iss_en   = 1'b1;
        iss_addr = 5'd3;
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd3};
        wr_data  = {32'h0, 32'h55};
        tick();
        idle();
        rd_addr = {5'd0, 5'd3};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h55 || rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL iss_prio data=%h busy=%b want 55/1",
                     rd_data[31:0], rd_busy[0]);
        end
        flush = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h55 || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL iss_flush data=%h busy=%b want 55/0",
                     rd_data[31:0], rd_busy[0]);
        end
    endtask

    task automatic test_flush_stall();
        iss_en   = 1'b1;
        iss_addr = 5'd4;
        tick();
        iss_addr = 5'd6;
        tick();
        idle();
        rd_addr = {5'd6, 5'd4};
        #1;
        checks++;
        if (rd_busy !== 2'b11) begin
            errors++;
            $display("FAIL two_issues busy=%b want 11", rd_busy);
        end
        stall    = 1'b1;
        flush    = 1'b1;
        iss_en   = 1'b1;
        iss_addr = 5'd13;
        tick();
        idle();
        rd_addr = {5'd13, 5'd4};
        #1;
        checks++;
        if (rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL flush_stalled busy=%b want 00", rd_busy);
        end
        flush    = 1'b1;
        iss_en   = 1'b1;
        iss_addr = 5'd13;
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy !== 2'b10) begin
            errors++;
            $display("FAIL flush_issue busy=%b want 10", rd_busy);
        end
        iss_en   = 1'b1;
        iss_addr = 5'd0;
        tick();
        idle();
        rd_addr = {5'd13, 5'd0};
        #1;
        checks++;
        if (rd_busy !== 2'b10 || rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL issue_x0 busy=%b data=%h want 10/0",
                     rd_busy, rd_data[31:0]);
        end
        flush = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d;
        logic        exp_b;
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd12};
        wr_data = {32'h0, 32'h1234};
        tick();
        idle();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd12};
        wr_data = {32'h0, 32'hABCD};
        rd_addr = {5'd0, 5'd12};
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        exp_d = 32'hABCD;
`else
        exp_d = 32'h1234;
`endif
        checks++;
        if (rd_data[31:0] !== exp_d || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bypass data=%h busy=%b want %h/0",
                     rd_data[31:0], rd_busy[0], exp_d);
        end
        iss_en   = 1'b1;
        iss_addr = 5'd12;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        exp_b = 1'b1;
`else
        exp_b = 1'b0;
`endif
        checks++;
        if (rd_data[31:0] !== exp_d || rd_busy[0] !== exp_b) begin
            errors++;
            $display("FAIL bypass_iss data=%h busy=%b want %h/%b",
                     rd_data[31:0], rd_busy[0], exp_d, exp_b);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hABCD || rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL bypass_after data=%h busy=%b want abcd/1",
                     rd_data[31:0], rd_busy[0]);
        end
    endtask

    task automatic test_reset_midop();
        for (int r = 1; r < 32; r += 2) begin
            wr_en    = 2'b11;
            wr_addr  = {5'(r + 1), 5'(r)};
            wr_data  = {32'hB000_0000 | 32'(r + 1), 32'hA000_0000 | 32'(r)};
            iss_en   = 1'b1;
            iss_addr = 5'(r);
            tick();
        end
        idle();
        rd_addr = {5'd6, 5'd5};
        #1;
        checks++;
        if (rd_data !== {32'hB000_0006, 32'hA000_0005} || rd_busy !== 2'b01) begin
            errors++;
            $display("FAIL fill data=%h busy=%b want b0000006a0000005/01",
                     rd_data, rd_busy);
        end
        rst      = 1'b1;
        stall    = 1'b1;
        flush    = 1'b1;
        wr_en    = 2'b11;
        wr_addr  = {5'd2, 5'd1};
        wr_data  = {32'hCAFE, 32'hBEEF};
        iss_en   = 1'b1;
        iss_addr = 5'd3;
        tick();
        idle();
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            checks++;
            if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
                errors++;
                $display("FAIL midop_reset a=%0d data=%h busy=%b want 0/00",
                         a, rd_data, rd_busy);
            end
        end
    endtask

    initial begin
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_addr = '0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_conflict();
        test_scoreboard();
        test_issue_priority();
        test_flush_stall();
        test_bypass();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, at least 2; AW = $clog2(NREGS).
REQ-003 SHALL have parameter NREAD, default 2: number of read ports, from 1 to 4.
REQ-004 SHALL have parameter NWRITE, default 2: number of write ports, from 1 to 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port stall, input, 1 bit: freezes all state updates except reset and flush.
REQ-008 SHALL have port rd_addr, input, NREAD*AW bits: read addresses; port i occupies slice i.
REQ-009 SHALL have port rd_data, output, NREAD*XLEN bits: read data.
REQ-010 SHALL have port rd_busy, output, NREAD bits: the addressed register has a pending write.
REQ-011 SHALL have port wr_en, input, NWRITE bits: write-port enables.
REQ-012 SHALL have port wr_addr, input, NWRITE*AW bits: write addresses.
REQ-013 SHALL have port wr_data, input, NWRITE*XLEN bits: write data.
REQ-014 SHALL have port iss_en, input, 1 bit: issue strobe that marks a destination as pending.
REQ-015 SHALL have port iss_addr, input, AW bits: destination marked by iss_en.
REQ-016 SHALL have port flush, input, 1 bit: clears all pending marks.

Function
REQ-017 SHALL implement register 0 as hardwired zero; writes to it are discarded, it is never marked busy, and a read of it returns 0 with busy 0.
REQ-018 SHALL provide combinational reads: rd_data[i] = reg[rd_addr[i]] and rd_busy[i] = busy[rd_addr[i]], with zero-cycle latency.
REQ-019 SHALL update a register at the rising clk edge when wr_en[k] is 1, wr_addr[k] is not 0, and stall is 0.
REQ-020 SHALL, when two write ports target the same address in one cycle, keep the data of the higher-index port; the lower-index port is dropped.
REQ-021 SHALL keep the register contents and the busy vector unchanged while stall is 1.
REQ-022 SHALL set busy[iss_addr] at the edge when iss_en is 1, iss_addr is not 0, and stall is 0.
REQ-023 SHALL clear busy[a] at the edge when any enabled write targets a and stall is 0.
REQ-024 SHALL give issue priority when an issue and a write to the same address occur in one cycle: the data is written and busy stays 1, because a new producer is pending.
REQ-025 SHALL clear all busy bits at the edge when flush is 1, regardless of stall, except for a same-cycle issue, which still sets its bit when stall is 0; register data is unaffected by flush.
REQ-026 SHALL treat a write to a non-busy register as legal: data is written and busy stays 0.

Reset
REQ-027 SHALL, when rst is 1 at a rising edge, clear every register to 0 and every busy bit to 0; rst overrides stall, flush, writes and issues.
REQ-028 SHALL, after reset, drive rd_data as all zeros and rd_busy as all zeros for any address.
REQ-029 SHALL return all state to zero on a reset asserted mid-operation, with no partially completed writes.

Configuration
REQ-030 SHALL, with REGFILE_MP_BYPASS_EN defined, forward data on each read port when an enabled, non-stalled write targets the same non-zero address in the same cycle: rd_data shows that wr_data (higher port wins) and rd_busy shows 0 unless a same-cycle issue targets the address.
REQ-031 SHALL, without REGFILE_MP_BYPASS_EN, return the pre-edge stored value and stored busy bit on reads, with no forwarding logic present.

Structure
REQ-032 SHALL place the defaults for XLEN, NREGS, NREAD and NWRITE and the AW helper function in the shared package regfile_pkg.
REQ-033 SHALL use the sub-module regfile_scoreboard to hold the busy vector and its set/clear/flush logic; data storage and the read muxes stay in regfile_mp.

Verification
REQ-034 SHALL verify write then read: write 0xDEADBEEF to x5 via port 0, next cycle rd_addr[0]=5 -> rd_data 0xDEADBEEF, busy 0.
REQ-035 SHALL verify the port conflict: port0 writes 0x1111 to x7 and port1 writes 0x2222 to x7 in the same cycle -> x7 = 0x2222; write to x0 -> reads 0.
REQ-036 SHALL verify the scoreboard: issue x9 -> busy 1; stall=1 with a write to x9 -> busy still 1 and data unchanged; stall=0 with the write -> busy 0.
REQ-037 SHALL verify issue priority: issue x3 and write x3=0x55 in the same cycle -> x3 = 0x55 and busy 1; flush -> busy 0.
REQ-038 SHALL verify bypass (macro defined): a write of 0xABCD to x12 with rd_addr=12 in the same cycle -> rd_data 0xABCD combinationally; without the macro -> old value.
REQ-039 SHALL verify reset: fill all registers and set busy bits, then assert rst together with stall=1 -> all reads 0 and all busy 0 on the next cycle.
